// File: rtl/demorgan_truth_table_sequencer.sv
// Steps a 3-input De Morgan gate pair through all 8 vectors and checks
// both outputs against (~a & ~b) | ~c, reporting pass, count and first failure.
module demorgan_truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_dut_lhs,
    input  logic       i_dut_rhs,
    output logic       o_drive_a,
    output logic       o_drive_b,
    output logic       o_drive_c,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_mismatch_cnt,
    output logic       o_fail_seen,
    output logic [2:0] o_first_fail_vec
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [2:0] r_vec;
    logic [3:0] r_settle_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_mismatch_cnt;
    logic       r_fail_seen;
    logic [2:0] r_first_fail_vec;

    logic w_golden;
    logic w_vec_fail;

    assign w_golden   = (~r_vec[2] & ~r_vec[1]) | ~r_vec[0];
    assign w_vec_fail = (i_dut_lhs != w_golden) || (i_dut_rhs != w_golden);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_vec            <= 3'd0;
            r_settle_cnt     <= 4'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_mismatch_cnt   <= 4'd0;
            r_fail_seen      <= 1'b0;
            r_first_fail_vec <= 3'd0;
        end else begin
            r_done <= 1'b0;
            // Abort in any active state drops the run but keeps partial counts.
            if (i_abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
                r_vec   <= 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_abort) begin
                            r_state          <= S_SETTLE;
                            r_vec            <= 3'd0;
                            r_settle_cnt     <= SETTLE_LOAD;
                            r_busy           <= 1'b1;
                            r_pass           <= 1'b0;
                            r_mismatch_cnt   <= 4'd0;
                            r_fail_seen      <= 1'b0;
                            r_first_fail_vec <= 3'd0;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt != 4'd0) begin
                            r_settle_cnt <= r_settle_cnt - 4'd1;
                        end else begin
                            r_state <= S_SAMPLE;
                        end
                    end
                    S_SAMPLE: begin
                        if (w_vec_fail) begin
                            r_mismatch_cnt <= r_mismatch_cnt + 4'd1;
                            if (!r_fail_seen) begin
                                r_fail_seen      <= 1'b1;
                                r_first_fail_vec <= r_vec;
                            end
                        end
                        if (r_vec == 3'd7) begin
                            r_state <= S_DONE;
                        end else begin
                            r_vec        <= r_vec + 3'd1;
                            r_settle_cnt <= SETTLE_LOAD;
                            r_state      <= S_SETTLE;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_pass  <= (r_mismatch_cnt == 4'd0);
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_drive_a        = r_vec[2];
    assign o_drive_b        = r_vec[1];
    assign o_drive_c        = r_vec[0];
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_mismatch_cnt   = r_mismatch_cnt;
    assign o_fail_seen      = r_fail_seen;
    assign o_first_fail_vec = r_first_fail_vec;

endmodule

// File: tb/tb_demorgan_truth_table_sequencer.sv
// Bench for demorgan_truth_table_sequencer: cycle-level reference model
// plus directed literal checks and randomized start/abort/reset traffic.
module tb_demorgan_truth_table_sequencer;

    localparam int S  = 1;
    localparam int S3 = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       s3_start = 1'b0;
    int         fault = 0;
    logic [7:0] mask_l = 8'h00;
    logic [7:0] mask_r = 8'h00;

    logic       drv_a, drv_b, drv_c;
    logic       dut_lhs, dut_rhs;
    logic       busy, done, pass, fail_seen;
    logic [3:0] mm_cnt;
    logic [2:0] first_vec;

    logic       d3_a, d3_b, d3_c, d3_lhs, d3_rhs;
    logic       d3_busy, d3_done, d3_pass, d3_seen;
    logic [3:0] d3_cnt;
    logic [2:0] d3_first;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    function automatic bit golden(int v);
        return (v % 2 == 0) || (v < 2);
    endfunction

    function automatic bit side_out(int v, bit rhs_side);
        bit g;
        g = golden(v);
        if (!rhs_side && fault == 2) return 1'b1;
        if (rhs_side && fault == 1) return 1'b0;
        if (fault == 3) return rhs_side ? (g ^ mask_r[v]) : (g ^ mask_l[v]);
        return g;
    endfunction

    assign dut_lhs = side_out(int'({drv_a, drv_b, drv_c}), 1'b0);
    assign dut_rhs = side_out(int'({drv_a, drv_b, drv_c}), 1'b1);
    assign d3_lhs  = golden(int'({d3_a, d3_b, d3_c}));
    assign d3_rhs  = golden(int'({d3_a, d3_b, d3_c}));

    demorgan_truth_table_sequencer #(.SETTLE_CYCLES(S)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_dut_lhs(dut_lhs), .i_dut_rhs(dut_rhs),
        .o_drive_a(drv_a), .o_drive_b(drv_b), .o_drive_c(drv_c),
        .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_mismatch_cnt(mm_cnt), .o_fail_seen(fail_seen),
        .o_first_fail_vec(first_vec)
    );

    demorgan_truth_table_sequencer #(.SETTLE_CYCLES(S3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(s3_start), .i_abort(1'b0),
        .i_dut_lhs(d3_lhs), .i_dut_rhs(d3_rhs),
        .o_drive_a(d3_a), .o_drive_b(d3_b), .o_drive_c(d3_c),
        .o_busy(d3_busy), .o_done(d3_done), .o_pass(d3_pass),
        .o_mismatch_cnt(d3_cnt), .o_fail_seen(d3_seen),
        .o_first_fail_vec(d3_first)
    );

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a timeline t = cycles since the start edge.
    bit m_active = 0;
    int m_t = 0;
    int m_vec = 0;
    int m_cnt = 0;
    bit m_seen = 0;
    int m_first = 0;
    bit m_pass = 0;
    bit m_busy = 0;
    bit m_done = 0;

    always @(posedge clk) begin
        int v;
        bit g;
        m_done = 0;
        if (rst) begin
            m_active = 0; m_t = 0; m_vec = 0; m_cnt = 0;
            m_seen = 0; m_first = 0; m_pass = 0; m_busy = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1; m_t = 0; m_vec = 0; m_cnt = 0;
                m_seen = 0; m_first = 0; m_pass = 0; m_busy = 1;
            end
        end else if (abort) begin
            m_active = 0; m_busy = 0; m_pass = 0; m_vec = 0;
        end else if (m_t == 8 * (S + 1)) begin
            m_active = 0; m_busy = 0; m_done = 1;
            m_pass = (m_cnt == 0);
        end else begin
            if (m_t % (S + 1) == S) begin
                v = m_t / (S + 1);
                g = golden(v);
                if (side_out(v, 1'b0) != g || side_out(v, 1'b1) != g) begin
                    if (!m_seen) m_first = v;
                    m_seen = 1;
                    m_cnt++;
                end
                if (v < 7) m_vec = v + 1;
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", int'(busy), int'(m_busy));
            chk("m_done", int'(done), int'(m_done));
            chk("m_pass", int'(pass), int'(m_pass));
            chk("m_cnt", int'(mm_cnt), m_cnt);
            chk("m_seen", int'(fail_seen), int'(m_seen));
            chk("m_first", int'(first_vec), m_first);
            chk("m_drive", int'({drv_a, drv_b, drv_c}), m_vec);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, input int lim);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!done && lat < lim);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input int flt, output int lat);
        fault = flt;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat, 60);
    endtask

    initial begin
        int lat;
        int n;
        step();
        step();
        chk_en = 1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_cnt", int'(mm_cnt), 0);
        chk("rst_drive", int'({drv_a, drv_b, drv_c}), 0);
        rst = 1'b0;
        step();

        run(0, lat);
        chk("t1_latency", lat, 17);
        chk("t1_pass", int'(pass), 1);
        chk("t1_cnt", int'(mm_cnt), 0);
        chk("t1_seen", int'(fail_seen), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_drive", int'({drv_a, drv_b, drv_c}), 7);

        run(1, lat);
        chk("t2_cnt", int'(mm_cnt), 5);
        chk("t2_first", int'(first_vec), 0);
        chk("t2_pass", int'(pass), 0);
        chk("t2_seen", int'(fail_seen), 1);

        run(2, lat);
        chk("t3_cnt", int'(mm_cnt), 3);
        chk("t3_first", int'(first_vec), 3);
        chk("t3_pass", int'(pass), 0);

        s3_start = 1'b1;
        step();
        s3_start = 1'b0;
        lat = 0;
        n = 0;
        do begin
            if (lat == 4) s3_start = 1'b1;
            if (lat == 5) s3_start = 1'b0;
            step();
            lat++;
        end while (!d3_done && lat < 80);
        chk("t4_latency", lat, 33);
        chk("t4_pass", int'(d3_pass), 1);
        for (int i = 0; i < 40; i++) begin
            if (d3_done) n++;
            step();
        end
        chk("t4_done_count", n, 1);

        fault = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while ({drv_a, drv_b, drv_c} != 3'd4 && n < 40) begin
            step();
            n++;
        end
        chk("t5_reach_vec4", int'({drv_a, drv_b, drv_c}), 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_drive", int'({drv_a, drv_b, drv_c}), 0);
        chk("t5_pass", int'(pass), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n++;
            step();
        end
        chk("t5_no_done", n, 0);

        fault = 3;
        mask_l = 8'h24;
        start = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("t6_busy", int'(busy), 0);
        chk("t6_cnt", int'(mm_cnt), 0);
        chk("t6_drive", int'({drv_a, drv_b, drv_c}), 0);
        step();
        step();
        chk("t6_busy_held", int'(busy), 0);
        rst = 1'b0;
        step();
        chk("t6_restart_busy", int'(busy), 1);
        start = 1'b0;
        wait_done(lat, 60);
        chk("t6_latency", lat, 17);
        chk("t6_cnt_run", int'(mm_cnt), 2);
        chk("t6_first", int'(first_vec), 2);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom % 4) == 0;
            abort = ($urandom % 48) == 0;
            rst = ($urandom % 400) == 0;
            if (i % 37 == 0) begin
                fault = int'($urandom % 4);
                mask_l = 8'($urandom);
                mask_r = 8'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
